// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder: frozen-masked message runs through log2(N) XOR
// butterfly stages, one per clock, then is offered as bits and BPSK LLRs.

module polar_llr_lane #(
  parameter int LLR_MAG = 64
) (
  input  logic       vld,
  input  logic       x,
  output logic [8:0] llr
);
  localparam logic [8:0] POS = 9'(LLR_MAG);
  localparam logic [8:0] NEG = 9'(-LLR_MAG);

  assign llr = !vld ? '0 : (x ? NEG : POS);
endmodule

module polar_encoder_seq #(
  parameter int             N           = 8,
  parameter int             LOG_N       = 3,
  parameter logic [N-1:0]   FROZEN_MASK = N'(8'b0001_0111),
  parameter int             LLR_MAG     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     u_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_codeword,
  output logic [9*N-1:0]   out_llr,
  output logic [15:0]      frame_cnt
);
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [N-1:0]              wreg;
  logic [SW-1:0]             s;
  logic [LOG_N-1:0][N-1:0]   stg;
  logic [N-1:0][8:0]         llr_v;
  logic                      accept, hs;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;

  // Every stage's butterfly result is built in parallel; s picks the live one.
  for (genvar g = 0; g < LOG_N; g++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> g) & 1) == 0) begin : g_xor
        assign stg[g][i] = wreg[i] ^ wreg[i + (1 << g)];
      end else begin : g_pass
        assign stg[g][i] = wreg[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = ENC;
      ENC:     if (s == S_LAST) state_nxt = DONE;
      DONE:    if (hs)          state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      wreg      <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          wreg <= u_in & ~FROZEN_MASK;
          s    <= '0;
        end
        ENC: begin
          wreg <= stg[s];
          s    <= s + 1'b1;
        end
        DONE: if (hs) frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign out_codeword = out_valid ? wreg : '0;

  for (genvar j = 0; j < N; j++) begin : g_lane
    polar_llr_lane #(.LLR_MAG(LLR_MAG)) u_lane (
      .vld (out_valid),
      .x   (wreg[j]),
      .llr (llr_v[j])
    );
  end

  assign out_llr = llr_v;
endmodule

// File: tb/tb_polar_encoder_seq.sv
// Bench for polar_encoder_seq: two instances (mask 0 and default mask) share
// stimulus and are checked every cycle against a subset-XOR reference model.

module tb_polar_encoder_seq;
  localparam int N = 8;
  localparam int LOG_N = 3;
  localparam int LLR_MAG = 64;
  localparam logic [N-1:0] MASK0 = 8'h00;
  localparam logic [N-1:0] MASK1 = 8'h17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] u_in = '0;

  logic rdy0, ov0, rdy1, ov1;
  logic [N-1:0] cw0, cw1;
  logic [9*N-1:0] llr0, llr1;
  logic [15:0] fc0, fc1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  polar_encoder_seq #(.N(N), .LOG_N(LOG_N), .FROZEN_MASK(MASK0), .LLR_MAG(LLR_MAG)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .u_in(u_in),
    .out_valid(ov0), .out_ready(out_ready), .out_codeword(cw0), .out_llr(llr0),
    .frame_cnt(fc0));

  polar_encoder_seq #(.N(N), .LOG_N(LOG_N), .FROZEN_MASK(MASK1), .LLR_MAG(LLR_MAG)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .u_in(u_in),
    .out_valid(ov1), .out_ready(out_ready), .out_codeword(cw1), .out_llr(llr1),
    .frame_cnt(fc1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // x_j = XOR of masked u_i over every i that contains all bits of j
  function automatic logic [N-1:0] encode(input logic [N-1:0] u, input logic [N-1:0] mask);
    logic [N-1:0] um, x;
    um = u & ~mask;
    x = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((j & ~i) == 0) x[j] = x[j] ^ um[i];
    return x;
  endfunction

  function automatic logic [9*N-1:0] to_llr(input logic [N-1:0] x);
    logic [9*N-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      v = x[j] ? -LLR_MAG : LLR_MAG;
      r[9*j +: 9] = v[8:0];
    end
    return r;
  endfunction

  // Reference model: busy flag, edges since acceptance, expected codewords.
  logic         m_busy;
  int           m_age;
  logic [N-1:0] m_cw0, m_cw1;
  logic [15:0]  m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_age <= 0; m_cw0 <= '0; m_cw1 <= '0; m_cnt <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1; m_age <= 0;
        m_cw0 <= encode(u_in, MASK0);
        m_cw1 <= encode(u_in, MASK1);
      end
    end else if (m_age >= LOG_N) begin
      if (out_ready) begin m_busy <= 1'b0; m_cnt <= m_cnt + 16'd1; end
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic ev;
    ev = m_busy && (m_age >= LOG_N);
    chk("in_ready0", rdy0, !m_busy);
    chk("in_ready1", rdy1, !m_busy);
    chk("out_valid0", ov0, ev);
    chk("out_valid1", ov1, ev);
    chk("codeword0", cw0, ev ? m_cw0 : '0);
    chk("codeword1", cw1, ev ? m_cw1 : '0);
    chk("llr0", llr0, ev ? to_llr(m_cw0) : '0);
    chk("llr1", llr1, ev ? to_llr(m_cw1) : '0);
    chk("frame_cnt0", fc0, m_cnt);
    chk("frame_cnt1", fc1, m_cnt);
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [N-1:0] u);
    int k = 0;
    while (!rdy0 && k < 50) begin @(negedge clk); k++; end
    if (!rdy0) chk("send_ready_timeout", 0, 1);
    in_valid = 1'b1; u_in = u;
    @(negedge clk);
    in_valid = 1'b0; u_in = N'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ov0 && lat < 50) begin @(negedge clk); lat++; end
    if (!ov0) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    logic [N-1:0] snap_cw;
    logic [9*N-1:0] snap_llr;
    logic [15:0] fc_before;

    // model pins
    chk("model_80_m0", encode(8'h80, MASK0), 8'hFF);
    chk("model_FF_m1", encode(8'hFF, MASK1), 8'h96);
    chk("model_llr_01", to_llr(8'h01), {{7{9'h040}}, 9'h1C0});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", rdy0, 1'b1);
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_codeword", cw0, 8'h00);
    chk("rst_llr", llr0, '0);
    chk("rst_frame_cnt", fc0, 16'd0);

    out_ready = 1'b1;
    send(8'h80);
    wait_valid(lat);
    chk("latency", lat, 3);
    chk("t2_cw", cw0, 8'hFF);
    chk("t2_llr", llr0, {8{9'h1C0}});
    @(negedge clk);
    chk("t2_frame_cnt", fc0, 16'd1);
    chk("t2_in_ready", rdy0, 1'b1);

    send(8'h01);
    wait_valid(lat);
    chk("t3_cw", cw0, 8'h01);
    chk("t3_llr", llr0, {{7{9'h040}}, 9'h1C0});
    chk("t3_cw_frozen", cw1, 8'h00);
    @(negedge clk);

    send(8'hFF);
    wait_valid(lat);
    chk("t4_cw_mask", cw1, 8'h96);
    chk("t4_cw_nomask", cw0, 8'h80);
    @(negedge clk);
    send(8'h17);
    wait_valid(lat);
    chk("t4_frozen_only", cw1, 8'h00);
    @(negedge clk);

    // backpressure
    out_ready = 1'b0;
    fc_before = fc0;
    send(8'h5A);
    wait_valid(lat);
    snap_cw = cw0; snap_llr = llr0;
    in_valid = 1'b1; u_in = 8'hA5;
    repeat (10) begin
      @(negedge clk);
      chk("bp_cw_stable", cw0, snap_cw);
      chk("bp_llr_stable", llr0, snap_llr);
      chk("bp_in_ready", rdy0, 1'b0);
    end
    chk("bp_cw_value", snap_cw, encode(8'h5A, MASK0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_frame_cnt", fc0, fc_before + 16'd1);
    chk("bp_in_ready_after", rdy0, 1'b1);
    chk("bp_out_valid_after", ov0, 1'b0);

    // reset during ENC stage 1
    send(8'h3C);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", ov0, 1'b0);
    chk("rst_mid_in_ready", rdy0, 1'b1);
    chk("rst_mid_frame_cnt", fc0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h80);
    wait_valid(lat);
    chk("rst_fresh_latency", lat, 3);
    chk("rst_fresh_cw", cw0, 8'hFF);
    @(negedge clk);

    // randomized frames with backpressure and ignored in_valid noise
    for (int f = 0; f < 40; f++) begin
      out_ready = 1'b0;
      send(N'($urandom));
      repeat ($urandom_range(0, 6)) begin
        in_valid = 1'($urandom); u_in = N'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      wait_valid(lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'($urandom);
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
